// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the byte-serial RAM arbiter: FSM states, access
// lengths, I/O window and the length-to-byte-count helper.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IF_RD  = 2'd1,
    MEM_RD = 2'd2,
    MEM_WR = 2'd3
  } state_t;

  localparam logic [1:0]  LEN_B = 2'd0;
  localparam logic [1:0]  LEN_H = 2'd1;
  localparam logic [1:0]  LEN_W = 2'd2;

  localparam logic [31:0] IO_BASE_DEF = 32'h0003_0000;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  // Length code 3 is not a legal access; it is treated as a word.
  function automatic logic [2:0] len_bytes(input logic [1:0] len);
    case (len)
      LEN_B:   return 3'd1;
      LEN_H:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl_byte_assembler.sv
// 32-bit little-endian word register filled one byte at a time; shared by the
// fetch and load paths. word_next exposes the insert so the last byte can be
// forwarded in the same edge it is captured.
module mem_ctrl_byte_assembler (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        load,
  input  logic [1:0]  idx,
  input  logic [7:0]  din,
  output logic [31:0] word_q,
  output logic [31:0] word_next
);

  always_comb begin
    word_next = word_q;
    word_next[{idx, 3'b000} +: 8] = din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word_q <= '0;
    end else if (clear) begin
      word_q <= '0;
    end else if (load) begin
      word_q <= word_next;
    end
  end

endmodule

// File: rtl/mem_ctrl.sv
// Byte-serial arbiter between IF/MEM and a single-port 8-bit RAM. MEM wins
// arbitration; words are split/assembled one byte per cycle.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int          ADDR_W  = 32,
  parameter logic [31:0] IO_BASE = IO_BASE_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [31:0]       if_inst,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [1:0]        mem_len,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic              mem_done,
  output logic [31:0]       mem_rdata,
  output logic              if_stall,
  output logic              mem_stall,
  input  logic [7:0]        ram_din,
  output logic [7:0]        ram_dout,
  output logic [ADDR_W-1:0] ram_a,
  output logic              ram_wr,
  input  logic              io_buffer_full
);

  state_t            state;
  logic [2:0]        cnt;
  logic [2:0]        n_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;

  logic              mem_io;
  logic              io_block;
  logic              acc_mem;
  logic              acc_if;
  logic [2:0]        n_new;
  logic [1:0]        idx;
  logic              rd_state;
  logic [31:0]       asm_q;
  logic [31:0]       asm_next;

  assign if_stall  = if_req & ~if_done;
  assign mem_stall = mem_req & ~mem_done;

  assign mem_io   = (mem_addr[17:16] == IO_BASE[17:16]);
  assign io_block = mem_req & mem_we & mem_io & io_buffer_full;
  // A request still held during its own done cycle must not be restarted.
  assign acc_mem  = (state == IDLE) & ~if_done & ~mem_done & mem_req & ~io_block;
  assign acc_if   = (state == IDLE) & ~if_done & ~mem_done & ~mem_req & if_req;
  assign n_new    = len_bytes(mem_len);
  assign idx      = cnt[1:0] - 2'd1;
  assign rd_state = (state == IF_RD) | (state == MEM_RD);

  mem_ctrl_byte_assembler u_asm (
    .clk       (clk),
    .rst       (rst),
    .clear     (rdy & (acc_mem | acc_if)),
    .load      (rdy & rd_state),
    .idx       (idx),
    .din       (ram_din),
    .word_q    (asm_q),
    .word_next (asm_next)
  );

  // RAM port is combinational so byte 0 goes out in the accept cycle.
  always_comb begin
    ram_a    = '0;
    ram_wr   = DISABLE;
    ram_dout = '0;
    if (rst) begin
      case (state)
        IDLE: begin
          if (acc_mem) begin
            ram_a = mem_addr;
            if (mem_we) begin
              ram_wr   = rdy;
              ram_dout = mem_wdata[7:0];
            end
          end else if (acc_if) begin
            ram_a = if_addr;
          end
        end
        MEM_WR: begin
          ram_a    = addr_q + ADDR_W'(cnt);
          ram_wr   = rdy;
          ram_dout = wdata_q[{cnt[1:0], 3'b000} +: 8];
        end
        IF_RD, MEM_RD: begin
          // While frozen, re-present the previous address so ram_din is
          // still the pending byte when rdy returns.
          if (!rdy) begin
            ram_a = addr_q + ADDR_W'(cnt) - ADDR_W'(1);
          end else if (cnt < n_q) begin
            ram_a = addr_q + ADDR_W'(cnt);
          end
        end
        default: ram_a = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      n_q       <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      if_done   <= DISABLE;
      mem_done  <= DISABLE;
      if_inst   <= '0;
      mem_rdata <= '0;
    end else if (rdy) begin
      if_done  <= DISABLE;
      mem_done <= DISABLE;
      case (state)
        IDLE: begin
          if (acc_mem) begin
            addr_q  <= mem_addr;
            n_q     <= n_new;
            wdata_q <= mem_wdata;
            cnt     <= 3'd1;
            if (!mem_we) begin
              state <= MEM_RD;
            end else if (n_new == 3'd1) begin
              mem_done <= ENABLE;
              cnt      <= '0;
            end else begin
              state <= MEM_WR;
            end
          end else if (acc_if) begin
            addr_q <= if_addr;
            n_q    <= 3'd4;
            cnt    <= 3'd1;
            state  <= IF_RD;
          end
        end
        MEM_WR: begin
          if (cnt == n_q - 3'd1) begin
            mem_done <= ENABLE;
            cnt      <= '0;
            state    <= IDLE;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        IF_RD, MEM_RD: begin
          if (cnt == n_q) begin
            if (state == IF_RD) begin
              if_done <= ENABLE;
              if_inst <= asm_next;
            end else begin
              mem_done  <= ENABLE;
              mem_rdata <= asm_next;
            end
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: stimulus pushes expected completions and RAM
// writes; a negedge monitor pops and compares them as the DUT presents them.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_inst;
  logic        mem_req;
  logic        mem_we;
  logic [1:0]  mem_len;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_done;
  logic [31:0] mem_rdata;
  logic        if_stall;
  logic        mem_stall;
  logic [7:0]  ram_din;
  logic [7:0]  ram_dout;
  logic [31:0] ram_a;
  logic        ram_wr;
  logic        io_buffer_full;

  mem_ctrl dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_inst(if_inst),
    .mem_req(mem_req), .mem_we(mem_we), .mem_len(mem_len), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_done(mem_done), .mem_rdata(mem_rdata),
    .if_stall(if_stall), .mem_stall(mem_stall),
    .ram_din(ram_din), .ram_dout(ram_dout), .ram_a(ram_a), .ram_wr(ram_wr),
    .io_buffer_full(io_buffer_full)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous byte RAM: read data appears the cycle after the address.
  logic [7:0] ram_m [0:262143];
  always @(posedge clk) begin
    if (ram_wr) ram_m[ram_a[17:0]] <= ram_dout;
    ram_din <= ram_m[ram_a[17:0]];
  end

  typedef struct { logic [31:0] data; int cyc; bit chk_data; } done_t;
  typedef struct { logic [31:0] addr; logic [7:0] data; int cyc; } wr_t;
  done_t iq[$];
  done_t mq[$];
  wr_t   wq[$];

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void exp_if(input logic [31:0] d, input int c);
    done_t e;
    e.data = d; e.cyc = c; e.chk_data = 1'b1;
    iq.push_back(e);
  endfunction

  function automatic void exp_mem(input logic [31:0] d, input int c, input bit cd);
    done_t e;
    e.data = d; e.cyc = c; e.chk_data = cd;
    mq.push_back(e);
  endfunction

  function automatic void exp_wr(input logic [31:0] a, input logic [7:0] d, input int c);
    wr_t e;
    e.addr = a; e.data = d; e.cyc = c;
    wq.push_back(e);
  endfunction

  always @(negedge clk) begin
    if (ram_wr) begin
      if (wq.size() == 0) begin
        chk("unexpected_ram_wr", {31'd0, ram_wr}, 32'd0);
      end else begin
        wr_t w;
        w = wq.pop_front();
        chk("wr_addr", ram_a, w.addr);
        chk("wr_data", {24'd0, ram_dout}, {24'd0, w.data});
        chk("wr_cycle", cyc, w.cyc);
      end
    end
    if (if_done) begin
      if (iq.size() == 0) begin
        chk("unexpected_if_done", {31'd0, if_done}, 32'd0);
      end else begin
        done_t e;
        e = iq.pop_front();
        chk("if_inst", if_inst, e.data);
        chk("if_done_cycle", cyc, e.cyc);
        chk("if_stall_at_done", {31'd0, if_stall}, 32'd0);
      end
    end
    if (mem_done) begin
      if (mq.size() == 0) begin
        chk("unexpected_mem_done", {31'd0, mem_done}, 32'd0);
      end else begin
        done_t e;
        e = mq.pop_front();
        if (e.chk_data) chk("mem_rdata", mem_rdata, e.data);
        chk("mem_done_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic start(input bit di, input logic [31:0] ia, input bit dm, input bit we,
                       input logic [1:0] len, input logic [31:0] ma, input logic [31:0] wd,
                       input bit iof, output int t0);
    @(posedge clk); #1;
    if_req = di; if_addr = ia;
    mem_req = dm; mem_we = we; mem_len = len; mem_addr = ma; mem_wdata = wd;
    io_buffer_full = iof;
    t0 = cyc;
  endtask

  // Acts as IF/MEM requester: drops each request the cycle after its done.
  task automatic finish(input int t0, input int io_cyc, input int rdy_at, input int rdy_len);
    bit md, id;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      md = mem_done; id = if_done;
      @(posedge clk); #1;
      if (md) mem_req = 1'b0;
      if (id) if_req = 1'b0;
      if (cyc - t0 >= io_cyc) io_buffer_full = 1'b0;
      rdy = !(rdy_len > 0 && cyc - t0 >= rdy_at && cyc - t0 < rdy_at + rdy_len);
      if (!if_req && !mem_req) return;
    end
    tests++; fails++;
    $display("FAIL timeout: requests still pending after 40 cycles (if_req=%0b mem_req=%0b)", if_req, mem_req);
    if_req = 1'b0; mem_req = 1'b0; rdy = 1'b1; io_buffer_full = 1'b0;
  endtask

  int t0;

  initial begin
    for (int i = 0; i < 262144; i++) ram_m[i] = 8'h00;
    ram_m[0] = 8'h13; ram_m[1] = 8'h05; ram_m[2] = 8'h10; ram_m[3] = 8'h00;
    ram_m[4] = 8'h93; ram_m[5] = 8'h05; ram_m[6] = 8'h20; ram_m[7] = 8'h00;
    ram_m[32'h100] = 8'h11; ram_m[32'h101] = 8'h22;
    ram_m[32'h102] = 8'h33; ram_m[32'h103] = 8'h44;

    rst = 1'b0; rdy = 1'b1; if_req = 1'b0; if_addr = '0; mem_req = 1'b0; mem_we = 1'b0;
    mem_len = 2'd0; mem_addr = '0; mem_wdata = '0; io_buffer_full = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_if_done", {31'd0, if_done}, 32'd0);
    chk("rst_mem_done", {31'd0, mem_done}, 32'd0);
    chk("rst_if_inst", if_inst, 32'd0);
    chk("rst_mem_rdata", mem_rdata, 32'd0);
    chk("rst_ram_a", ram_a, 32'd0);
    chk("rst_ram_wr", {31'd0, ram_wr}, 32'd0);
    chk("rst_ram_dout", {24'd0, ram_dout}, 32'd0);
    rst = 1'b1;

    // Fetch word at 0x0, stall held through cycles 0-4.
    start(1, 32'h0, 0, 0, 2'd0, 32'h0, 32'h0, 0, t0);
    exp_if(32'h0010_0513, t0 + 5);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("if_stall_busy", {31'd0, if_stall}, 32'd1);
    end
    finish(t0, 0, 0, 0);

    // Simultaneous fetch and load word: MEM first, IF accepted in cycle 6.
    start(1, 32'h4, 1, 0, 2'd2, 32'h100, 32'h0, 0, t0);
    exp_mem(32'h4433_2211, t0 + 5, 1);
    exp_if(32'h0020_0593, t0 + 11);
    finish(t0, 0, 0, 0);

    // Store half; only the low bytes of wdata are used.
    start(0, 32'h0, 1, 1, 2'd1, 32'h200, 32'h1234_BEEF, 0, t0);
    exp_wr(32'h200, 8'hEF, t0);
    exp_wr(32'h201, 8'hBE, t0 + 1);
    exp_mem(32'h0, t0 + 2, 0);
    finish(t0, 0, 0, 0);

    start(0, 32'h0, 1, 0, 2'd1, 32'h200, 32'h0, 0, t0);
    exp_mem(32'h0000_BEEF, t0 + 3, 1);
    finish(t0, 0, 0, 0);

    start(0, 32'h0, 1, 0, 2'd0, 32'h201, 32'h0, 0, t0);
    exp_mem(32'h0000_00BE, t0 + 2, 1);
    finish(t0, 0, 0, 0);

    // I/O store held off for 3 cycles by a full buffer.
    start(0, 32'h0, 1, 1, 2'd0, 32'h3_0000, 32'h0000_0041, 1, t0);
    exp_wr(32'h3_0000, 8'h41, t0 + 3);
    exp_mem(32'h0, t0 + 4, 0);
    finish(t0, 3, 0, 0);

    // rdy low in cycles 2-3 of a word read: done slips by exactly 2.
    start(0, 32'h0, 1, 0, 2'd2, 32'h100, 32'h0, 0, t0);
    exp_mem(32'h4433_2211, t0 + 7, 1);
    finish(t0, 0, 2, 2);

    // Reset in cycle 2 of a word store.
    start(0, 32'h0, 1, 1, 2'd2, 32'h300, 32'hCAFE_F00D, 0, t0);
    exp_wr(32'h300, 8'h0D, t0);
    exp_wr(32'h301, 8'hF0, t0 + 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("mid_rst_ram_wr", {31'd0, ram_wr}, 32'd0);
    chk("mid_rst_ram_a", ram_a, 32'd0);
    chk("mid_rst_ram_dout", {24'd0, ram_dout}, 32'd0);
    chk("mid_rst_if_inst", if_inst, 32'd0);
    chk("mid_rst_mem_rdata", mem_rdata, 32'd0);
    chk("mid_rst_mem_done", {31'd0, mem_done}, 32'd0);
    mem_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    chk("wr_queue_after_rst", wq.size(), 32'd0);

    start(1, 32'h0, 0, 0, 2'd0, 32'h0, 32'h0, 0, t0);
    exp_if(32'h0010_0513, t0 + 5);
    finish(t0, 0, 0, 0);

    repeat (4) @(posedge clk);
    #1;
    chk("if_queue_empty", iq.size(), 32'd0);
    chk("mem_queue_empty", mq.size(), 32'd0);
    chk("wr_queue_empty", wq.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Byte-serial memory arbiter between the pipeline and the single-port 8-bit RAM. It serves instruction fetches from IF and loads/stores from MEM, assembling or splitting words one byte per cycle. It is the main source of `if_stall` and `mem_stall` requests into the stall controller, and it deasserts each request in the cycle its data is ready.

## Interface
- `ADDR_W`, default 32: byte-address width.
- `IO_BASE`, default 32'h30000: addresses with `addr[17:16]==2'b11` are I/O and are gated by `io_buffer_full`.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `rdy`  in  1  global enable; when low, all state is frozen and `mem_wr`=0.
- `if_req`  in  1  IF fetch request, held stable until `if_done`.
- `if_addr`  in  32  fetch address, word-aligned.
- `if_done`  out  1  one-cycle pulse; `if_inst` is valid.
- `if_inst`  out  32  fetched instruction, little-endian.
- `mem_req`  in  1  MEM access request, held stable until `mem_done`.
- `mem_we`  in  1  1 = store, 0 = load.
- `mem_len`  in  2  access length: 0 = byte, 1 = half, 2 = word.
- `mem_addr`  in  32  access address.
- `mem_wdata`  in  32  store data; low bytes used.
- `mem_done`  out  1  one-cycle pulse; the access is complete.
- `mem_rdata`  out  32  load data, zero-extended. MEM applies sign extension.
- `if_stall`  out  1  `if_req & ~if_done`, combinational.
- `mem_stall`  out  1  `mem_req & ~mem_done`, combinational.
- `ram_din`  in  8  RAM read byte. Valid one cycle after the address.
- `ram_dout`  out  8  RAM write byte.
- `ram_a`  out  32  RAM byte address.
- `ram_wr`  out  1  1 = write this cycle.
- `io_buffer_full`  in  1  UART buffer full.

## Operation
- FSM states: IDLE, IF_RD, MEM_RD, MEM_WR. Byte counter `cnt[2:0]`. Byte count N = 1, 2 or 4; IF always uses N = 4.
- IDLE accepts a new access only when `done` is low, so a request still held in its done cycle is not restarted.
- IDLE arbitration: `mem_req` beats `if_req`, because MEM holds the older instruction.
  - Store: drive byte 0 (`ram_wr`=1, `ram_a`=addr) in the accept cycle. Go to MEM_WR with cnt=1.
  - Load/fetch: drive `ram_a`=addr, `ram_wr`=0. Go to MEM_RD/IF_RD with cnt=1.
- Store to an I/O address while `io_buffer_full`=1: stay in IDLE with `ram_wr`=0 and retry every cycle.
- MEM_WR: each cycle write byte `cnt` at addr+cnt, then cnt++. After byte N-1 is written, pulse `mem_done` and return to IDLE.
- IF_RD/MEM_RD: each cycle capture `ram_din` into byte `cnt-1`. While cnt<N, also drive `ram_a`=addr+cnt. When cnt==N, capture the last byte, pulse done next cycle, and return to IDLE.
- In IDLE with no accepted access: `ram_wr`=0, `ram_a`=0.
- `rdy`=0: FSM, counter, data registers and done pulses all hold. `ram_wr` is forced to 0.
- A request cannot drop mid-access; the stall freezes the requester. Behaviour if it does drop is undefined.
- Reset: state IDLE, cnt=0. All outputs 0: `if_done`, `mem_done`, `if_inst`, `mem_rdata`, `ram_a`, `ram_dout`, `ram_wr`.

## Timing
- Word read: request seen in cycle 0, bytes captured in cycles 1–4, done high in cycle 5. Latency 5.
- Half read: latency 3. Byte read: latency 2.
- Word write: bytes written in cycles 0–3, done in cycle 4. Half write: done in cycle 2. Byte write: done in cycle 1.
- Back-to-back: the earliest next accept is the cycle after done.
- Address arithmetic is modulo 2^32; wrap at 0xFFFFFFFF is permitted.

## Structure
- Shared package/`config.v`: state encodings, `LEN_B`/`LEN_H`/`LEN_W`, `IO_BASE`, and reuse of `Enable`/`Disable`.
- A single module. An optional sub-module `byte_assembler` holds the 32-bit shift/insert register used by both read paths.

## Test plan
- Fetch at 0x0 of RAM {0x13,0x05,0x10,0x00} → `if_done` in cycle 5, `if_inst`=0x00100513, `if_stall` high in cycles 0–4.
- Simultaneous `if_req`@0x4 and load word @0x100 → MEM served first (done in cycle 5), IF accepted in cycle 6, done in cycle 11.
- Store half 0xBEEF @0x200 → `ram_wr` high in cycles 0–1 (0xEF @0x200, 0xBE @0x201), `mem_done` in cycle 2. A read-back then returns 0x0000BEEF.
- Store byte 0x41 @0x30000 with `io_buffer_full`=1 for 3 cycles → no write in cycles 0–2, write in cycle 3, done in cycle 4.
- `rdy` low for 2 cycles in the middle of a word read → done is delayed by exactly 2 cycles, the data is unchanged, and `ram_wr` stays 0.
- Reset asserted in the middle of a store → all outputs 0 immediately. After release, IDLE and a fresh fetch completes normally.
